mem_wb_hilo: RTL and testbench

//   MEM/WB pipeline register plus architectural HI/LO register pair; the consuming end of
//   the MEM stage's writeback bundle (wd/wdata/wreg, whilo/hi/lo).

---
 rtl/mem_wb_hilo.sv | 93 +++++++++
 tb/tb_mem_wb_hilo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_hilo.sv
// mem_wb_hilo: MEM/WB pipeline register plus the architectural HI/LO pair.
// Latches the MEM-stage writeback bundle, drives the GPR write port, commits
// HI/LO one edge after they reach WB, and serves a HI/LO read port to EX.
// Optional feature macro: HILO_BYPASS_EN. When defined, the EX read port
// forwards in-flight HI/LO values from MEM (youngest) and then WB.
// When undefined, EX sees only the committed HI/LO. In that case the hazard
// unit must stall EX for two cycles after any HI/LO producer.
module mem_wb_hilo #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wreg,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic [REG_AW-1:0] wb_wd,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] rd_hi_o,
  output logic [DATA_W-1:0] rd_lo_o
);

  // HI/LO half of the WB latch; not visible outside except through the bypass.
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;

  // MEM/WB latch. Reset beats flush, flush beats stall, stall beats load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wd    <= '0;
      wb_wdata <= '0;
      wb_wreg  <= 1'b0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (flush_i) begin
      wb_wd    <= '0;
      wb_wdata <= '0;
      wb_wreg  <= 1'b0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (!stall_i) begin
      wb_wd    <= mem_wd;
      wb_wdata <= mem_wdata;
      wb_wreg  <= mem_wreg;
      wb_whilo <= mem_whilo;
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
    end
  end

  // HI/LO commit from the pre-edge WB latch. This is independent of stall/flush.
  // A held write during a stall simply rewrites the same values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (wb_whilo) begin
      hi_o <= wb_hi;
      lo_o <= wb_lo;
    end
  end

  // EX read port: the youngest in-flight HI/LO value wins when bypass is enabled.
  always_comb begin
`ifdef HILO_BYPASS_EN
    if (mem_whilo) begin
      rd_hi_o = mem_hi;
      rd_lo_o = mem_lo;
    end else if (wb_whilo) begin
      rd_hi_o = wb_hi;
      rd_lo_o = wb_lo;
    end else begin
      rd_hi_o = hi_o;
      rd_lo_o = lo_o;
    end
`else
    rd_hi_o = hi_o;
    rd_lo_o = lo_o;
`endif
  end

endmodule

// File: tb/tb_mem_wb_hilo.sv
// tb_mem_wb_hilo: scoreboard bench for mem_wb_hilo.
// The stimulus process drives one cycle of inputs and pushes the expected outputs
// for that cycle. The expected values come from a small behavioural model.
// A monitor process pops each expected record on the falling edge and compares it.
module tb_mem_wb_hilo;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, mem_wreg, mem_whilo;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata, hi_o, lo_o, rd_hi_o, rd_lo_o;
  logic        wb_wreg;

  mem_wb_hilo #(.REG_AW(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_wd(wb_wd), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg),
    .hi_o(hi_o), .lo_o(lo_o), .rd_hi_o(rd_hi_o), .rd_lo_o(rd_lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        wreg;
    logic [31:0] hi, lo, rd_hi, rd_lo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: the WB bundle as a record, plus the committed HI/LO pair.
  typedef struct {
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        wreg;
    logic        whilo;
    logic [31:0] hi, lo;
  } bundle_t;

  bundle_t     wbm;
  logic [31:0] arch_hi, arch_lo;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one comparison set per cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check32("wb_wd",    {27'd0, wb_wd},   {27'd0, e.wd});
        check32("wb_wdata", wb_wdata,         e.wdata);
        check32("wb_wreg",  {31'd0, wb_wreg}, {31'd0, e.wreg});
        check32("hi_o",     hi_o,             e.hi);
        check32("lo_o",     lo_o,             e.lo);
        check32("rd_hi_o",  rd_hi_o,          e.rd_hi);
        check32("rd_lo_o",  rd_lo_o,          e.rd_lo);
        $display("cycle t=%0t rst=%0b fl=%0b st=%0b wd=%0d wdata=%08h wreg=%0b hi=%08h lo=%08h rdhi=%08h",
                 $time, rst, flush_i, stall_i, wb_wd, wb_wdata, wb_wreg, hi_o, lo_o, rd_hi_o);
      end
    end
  end

  // Drive one cycle, predict what is visible during it, then advance the model across the edge.
  task automatic cyc(input logic r, input logic f, input logic s, input logic w, input logic wh,
                     input logic [4:0] wd, input logic [31:0] d, input logic [31:0] h,
                     input logic [31:0] l);
    exp_t    e;
    bundle_t incoming;
    rst = r; flush_i = f; stall_i = s; mem_wreg = w; mem_whilo = wh;
    mem_wd = wd; mem_wdata = d; mem_hi = h; mem_lo = l;

    e.wd = wbm.wd; e.wdata = wbm.wdata; e.wreg = wbm.wreg;
    e.hi = arch_hi; e.lo = arch_lo;
`ifdef HILO_BYPASS_EN
    e.rd_hi = wh ? h : (wbm.whilo ? wbm.hi : arch_hi);
    e.rd_lo = wh ? l : (wbm.whilo ? wbm.lo : arch_lo);
`else
    e.rd_hi = arch_hi;
    e.rd_lo = arch_lo;
`endif
    sb.push_back(e);

    incoming = '{wd: wd, wdata: d, wreg: w, whilo: wh, hi: h, lo: l};
    if (r) begin
      wbm = '{default: '0};
      arch_hi = '0;
      arch_lo = '0;
    end else begin
      if (wbm.whilo) begin
        arch_hi = wbm.hi;
        arch_lo = wbm.lo;
      end
      if (f) wbm = '{default: '0};
      else if (!s) wbm = incoming;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 5'($urandom), $urandom, $urandom, $urandom);
  endtask

  initial begin
    int wait_cnt;
    // First reset edge: DUT state is unknown before it, so nothing is checked yet.
    rst = 1; flush_i = 0; stall_i = 0; mem_wreg = 1; mem_whilo = 1;
    mem_wd = 5'($urandom); mem_wdata = $urandom; mem_hi = $urandom; mem_lo = $urandom;
    wbm = '{default: '0}; arch_hi = '0; arch_lo = '0;
    @(posedge clk);
    #1;

    // Reset held with random MEM traffic, then release and load.
    cyc(1, 0, 0, 1, 0, 5'($urandom), $urandom, $urandom, $urandom);
    cyc(0, 0, 0, 1, 0, 5'($urandom), $urandom, $urandom, $urandom);
    idle();

    // Plain GPR writeback, then r0 write passed through unchanged.
    cyc(0, 0, 0, 1, 0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0);
    cyc(0, 0, 0, 1, 0, 5'd0, 32'hCAFEF00D, 32'h0, 32'h0);
    idle();

    // HI/LO write and its two-edge commit.
    cyc(0, 0, 0, 0, 1, 5'd0, 32'h0, 32'h11112222, 32'h33334444);
    idle(); idle(); idle();

    // Stall for three cycles with changing MEM, then flush while stalled.
    cyc(0, 0, 0, 1, 1, 5'd9, 32'h0BADCAFE, 32'hAAAA0001, 32'hBBBB0001);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 1, 1, 5'($urandom), $urandom, $urandom, $urandom);
    cyc(0, 1, 1, 1, 1, 5'($urandom), $urandom, $urandom, $urandom);
    idle(); idle();

    // Back-to-back HI/LO writers.
    cyc(0, 0, 0, 0, 1, 5'd0, 32'h0, 32'hA0A0A0A0, 32'hA1A1A1A1);
    cyc(0, 0, 0, 0, 1, 5'd0, 32'h0, 32'hB0B0B0B0, 32'hB1B1B1B1);
    idle(); idle(); idle();

    // Reset while a HI/LO commit is pending in WB.
    cyc(0, 0, 0, 0, 1, 5'd0, 32'h0, 32'hC0C0C0C0, 32'hC1C1C1C1);
    cyc(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    idle(); idle();

    // Random traffic with occasional reset, flush and stall.
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10),
          ($urandom_range(0, 99) < 25), 1'($urandom), 1'($urandom),
          5'($urandom), $urandom, $urandom, $urandom);
    end
    idle();

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
